// File: rtl/aes_decrypt_ctrl.sv
// Iterative AES-128 decryption controller: one shared inverse-round datapath,
// round keys fetched by index from an external expanded-key store.
module aes_decrypt_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ciphertext,
    output logic [3:0]   rk_addr,
    input  logic [127:0] rk_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plaintext,
    output logic         busy
);

    localparam int unsigned BLK_W = 128;
    localparam int unsigned RND_W = 4;
    localparam logic [RND_W-1:0] LAST_KEY  = RND_W'(10);
    localparam logic [RND_W-1:0] FIRST_RND = RND_W'(9);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    state_t           state;
    logic [BLK_W-1:0] st;
    logic [RND_W-1:0] rnd;
    logic             accept;
    logic [BLK_W-1:0] ark;
    logic [BLK_W-1:0] round_out;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128); maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] y;
        y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(y);
    endfunction

    // Byte k of the block sits at bits [127-8k -: 8]; byte 4c+r is row r, column c.
    function automatic logic [BLK_W-1:0] inv_shift_sub(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c+4-r)%4)+r) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [BLK_W-1:0] inv_mix(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    // Shared datapath: the final round simply skips InvMixColumns.
    always_comb begin
        ark       = inv_shift_sub(st) ^ rk_data;
        round_out = inv_mix(ark);
    end

    // DONE also presents key 10 so a consume-and-accept cycle can load the next block.
    always_comb begin
        rk_addr = LAST_KEY;
        case (state)
            IDLE:    rk_addr = LAST_KEY;
            ROUND:   rk_addr = rnd;
            FINAL:   rk_addr = '0;
            DONE:    rk_addr = LAST_KEY;
            default: rk_addr = LAST_KEY;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE) || ((state == DONE) && out_ready);
        accept   = in_valid && in_ready;
    end

    assign plaintext = st;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            st        <= '0;
            rnd       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        st    <= ciphertext ^ rk_data;
                        rnd   <= FIRST_RND;
                        busy  <= 1'b1;
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    st  <= round_out;
                    rnd <= rnd - RND_W'(1);
                    if (rnd == RND_W'(1)) state <= FINAL;
                end
                FINAL: begin
                    st        <= ark;
                    busy      <= 1'b0;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (accept) begin
                            st    <= ciphertext ^ rk_data;
                            rnd   <= FIRST_RND;
                            busy  <= 1'b1;
                            state <= ROUND;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_decrypt_ctrl.sv
// Directed and random checks of aes_decrypt_ctrl against FIPS-197 C.1 and a
// forward-direction AES-128 software model that produces the ciphertexts.
module tb_aes_decrypt_ctrl;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] ciphertext;
    logic [3:0]   rk_addr;
    logic [127:0] rk_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] plaintext;
    logic         busy;

    logic [7:0]   sbox_t [256];
    logic [127:0] rk_mem [11];

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    // Expanded-key store with a combinational read.
    assign rk_data = (rk_addr <= 4'd10) ? rk_mem[rk_addr] : '0;

    aes_decrypt_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ciphertext (ciphertext),
        .rk_addr    (rk_addr),
        .rk_data    (rk_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .plaintext  (plaintext),
        .busy       (busy)
    );

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // Forward S-box: inverse by exhaustive search, then the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_t[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                        {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    task automatic load_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] pt);
        logic [127:0] s;
        logic [127:0] t;
        logic [7:0] a0, a1, a2, a3;
        s = pt ^ rk_mem[0];
        for (int r = 1; r <= 10; r++) begin
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++)
                    t[127-8*(4*c+w) -: 8] = sbox_t[s[127-8*(4*((c+w)%4)+w) -: 8]];
            if (r < 10) begin
                s = t;
                for (int c = 0; c < 4; c++) begin
                    a0 = s[127-32*c -: 8];
                    a1 = s[119-32*c -: 8];
                    a2 = s[111-32*c -: 8];
                    a3 = s[103-32*c -: 8];
                    t[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    t[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    t[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    t[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            s = t ^ rk_mem[r];
        end
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one block from IDLE; n = edges from the accept edge until out_valid is seen.
    task automatic run_block(input logic [127:0] ct, output int n);
        ciphertext = ct;
        in_valid   = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; ciphertext = '0;
        tick(); tick();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (rk_addr !== 4'd10) $display("FAIL reset_rk_addr: got %0d want 10", rk_addr); else pass_cnt++;
        total_cnt++; if (plaintext !== 128'h0) $display("FAIL reset_plaintext: got %h want 0", plaintext); else pass_cnt++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_c1();
        logic [3:0] trace [16];
        int n;
        int ti;
        load_key(C1_KEY);
        ciphertext = C1_CT; in_valid = 1'b1; out_ready = 1'b1;
        trace[0] = rk_addr;
        tick();
        in_valid = 1'b0;
        n = 1; ti = 1;
        while (!out_valid && n < 40) begin
            if (ti < 16) trace[ti] = rk_addr;
            ti++;
            tick();
            n++;
        end
        total_cnt++; if (n != 11) $display("FAIL c1_latency: got %0d want 11", n); else pass_cnt++;
        total_cnt++; if (ti != 11) $display("FAIL c1_trace_len: got %0d want 11", ti); else pass_cnt++;
        for (int i = 0; i < 11; i++) begin
            total_cnt++;
            if (trace[i] !== 4'(10 - i)) $display("FAIL c1_rk_addr[%0d]: got %0d want %0d", i, trace[i], 10 - i);
            else pass_cnt++;
        end
        total_cnt++; if (plaintext !== C1_PT) $display("FAIL c1_plaintext: got %h want %h", plaintext, C1_PT); else pass_cnt++;
        tick();
        total_cnt++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL c1_consumed: got %b want 01", {out_valid, in_ready}); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int n;
        out_ready = 1'b0;
        run_block(C1_CT, n);
        total_cnt++; if (n != 11) $display("FAIL bp_latency: got %0d want 11", n); else pass_cnt++;
        for (int i = 0; i < 20; i++) begin
            total_cnt++;
            if ({out_valid, in_ready, plaintext} !== {1'b1, 1'b0, C1_PT})
                $display("FAIL bp_hold[%0d]: got v=%b r=%b %h want v=1 r=0 %h", i, out_valid, in_ready, plaintext, C1_PT);
            else pass_cnt++;
            tick();
        end
        out_ready = 1'b1;
        #1;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_ready_rise: got %b want 1", in_ready); else pass_cnt++;
        tick();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_release: got %b want 0", out_valid); else pass_cnt++;
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n;
        ciphertext = C1_CT; in_valid = 1'b1; out_ready = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!out_valid && n < 40);
        total_cnt++; if (n != 11) $display("FAIL b2b_first_latency: got %0d want 11", n); else pass_cnt++;
        total_cnt++; if (plaintext !== C1_PT) $display("FAIL b2b_first_pt: got %h want %h", plaintext, C1_PT); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL b2b_bypass_ready: got %b want 1", in_ready); else pass_cnt++;
        tick();
        total_cnt++;
        if ({out_valid, busy, rk_addr} !== {1'b0, 1'b1, 4'd9})
            $display("FAIL b2b_second_accept: got v=%b busy=%b rk=%0d want v=0 busy=1 rk=9", out_valid, busy, rk_addr);
        else pass_cnt++;
        n = 1;
        while (!out_valid && n < 40) begin tick(); n++; end
        in_valid = 1'b0;
        total_cnt++; if (n != 11) $display("FAIL b2b_second_latency: got %0d want 11", n); else pass_cnt++;
        total_cnt++; if (plaintext !== C1_PT) $display("FAIL b2b_second_pt: got %h want %h", plaintext, C1_PT); else pass_cnt++;
        tick();
        total_cnt++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL b2b_drain: got %b want 01", {out_valid, in_ready}); else pass_cnt++;
    endtask

    task automatic test_reset_mid_block();
        int n;
        bit seen;
        out_ready = 1'b1;
        ciphertext = C1_CT; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL mid_rst_out_valid: got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL mid_rst_in_ready: got %b want 1", in_ready); else pass_cnt++;
        total_cnt++; if (rk_addr !== 4'd10) $display("FAIL mid_rst_rk_addr: got %0d want 10", rk_addr); else pass_cnt++;
        total_cnt++; if (plaintext !== 128'h0) $display("FAIL mid_rst_plaintext: got %h want 0", plaintext); else pass_cnt++;
        tick();
        rst = 1'b0;
        seen = 1'b0;
        repeat (15) begin tick(); if (out_valid) seen = 1'b1; end
        total_cnt++; if (seen !== 1'b0) $display("FAIL mid_rst_no_output: got %b want 0", seen); else pass_cnt++;
        run_block(C1_CT, n);
        total_cnt++; if (n != 11) $display("FAIL mid_rst_next_latency: got %0d want 11", n); else pass_cnt++;
        total_cnt++; if (plaintext !== C1_PT) $display("FAIL mid_rst_next_pt: got %h want %h", plaintext, C1_PT); else pass_cnt++;
        tick();
    endtask

    task automatic test_busy();
        int busy_cnt;
        int acc;
        out_ready = 1'b0;
        ciphertext = C1_CT; in_valid = 1'b1;
        #1;
        acc = (in_ready && in_valid) ? 1 : 0;
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy) busy_cnt++;
            if (in_ready && in_valid) acc++;
        end
        total_cnt++; if (busy_cnt != 10) $display("FAIL busy_cycles: got %0d want 10", busy_cnt); else pass_cnt++;
        total_cnt++; if (acc != 1) $display("FAIL busy_accepts: got %0d want 1", acc); else pass_cnt++;
        total_cnt++; if ({out_valid, plaintext} !== {1'b1, C1_PT}) $display("FAIL busy_result: got v=%b %h want v=1 %h", out_valid, plaintext, C1_PT); else pass_cnt++;
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total_cnt++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL busy_drain: got %b want 01", {out_valid, in_ready}); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
        int n;
        int k;
        for (int it = 0; it < 1000; it++) begin
            key = {$urandom(), $urandom(), $urandom(), $urandom()};
            pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
            load_key(key);
            ct = encrypt(pt);
            out_ready = 1'b0;
            run_block(ct, n);
            total_cnt++; if (n != 11) $display("FAIL rand_latency[%0d]: got %0d want 11", it, n); else pass_cnt++;
            total_cnt++; if (plaintext !== pt) $display("FAIL rand_pt[%0d]: got %h want %h", it, plaintext, pt); else pass_cnt++;
            k = int'($urandom_range(0, 4));
            repeat (k) tick();
            total_cnt++;
            if ({out_valid, plaintext} !== {1'b1, pt}) $display("FAIL rand_stall[%0d]: got v=%b %h want v=1 %h", it, out_valid, plaintext, pt);
            else pass_cnt++;
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, total_cnt);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; ciphertext = '0;
        for (int r = 0; r < 11; r++) rk_mem[r] = '0;
        build_sbox();
        test_reset();
        test_c1();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_block();
        test_busy();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/aes_decrypt_ctrl.md
# aes_decrypt_ctrl

Iterative AES-128 decryption controller that schedules a single shared `decryptRound` datapath instance over ten rounds per block. It accepts one ciphertext block over a valid/ready handshake and fetches round keys from an external expanded-key store by index. It applies the initial AddRoundKey, nine full inverse rounds and the final round without InvMixColumns. It returns the plaintext over a second valid/ready handshake and sits between the key-expansion store and the system bus wrapper.

## Interface
Parameters:
- None. AES-128 only; round count is fixed at 10.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  the `ciphertext` input holds a block to decrypt.
- `in_ready`  out  1  the block accepts a ciphertext this cycle.
- `ciphertext`  in  128  input block; sampled only on accept.
- `rk_addr`  out  4  round-key index requested from the key store (0..10).
- `rk_data`  in  128  round key for `rk_addr`, combinational same-cycle read.
- `out_valid`  out  1  the `plaintext` output is valid.
- `out_ready`  in  1  the consumer takes `plaintext` this cycle.
- `plaintext`  out  128  decrypted block; stable while `out_valid` is high.
- `busy`  out  1  high in ROUND and FINAL.

## Operation
- State register `st` (128 b), round counter `rnd` (4 b), FSM states IDLE, ROUND, FINAL, DONE.
- IDLE: `rk_addr`=10. On accept (`in_valid & in_ready`): `st <= ciphertext ^ rk_data`, `rnd <= 9`, go to ROUND.
- ROUND: `rk_addr`=`rnd`. `st <= decryptRound(st, rk_data)`, which applies InvShiftRows, InvSubBytes, AddRoundKey and InvMixColumns. Decrement `rnd`. When `rnd`==1 this cycle, go to FINAL.
- FINAL: `rk_addr`=0. `st <= InvSubBytes(InvShiftRows(st)) ^ rk_data`, with no InvMixColumns. Go to DONE.
- DONE: `out_valid`=1 and `plaintext`=`st`. Hold until `out_ready`.
  - On `out_ready` with no new accept, go to IDLE.
  - `in_ready` = (state==IDLE) | (state==DONE & out_ready).
  - If DONE, `out_ready` and `in_valid` are all high in the same cycle, the output is consumed and the new block is accepted in that same cycle. The accept uses `rk_addr`=10, so in DONE `rk_addr` is driven to 10. The FSM goes directly to ROUND.
- `ciphertext` and `rk_data` are ignored outside the cycles listed above. `in_valid` in ROUND or FINAL is not accepted (`in_ready`=0) and is held off by the source.
- No abort input. Reset is the only way to cancel a block in flight.

## Timing
- Reset values (asynchronous): state=IDLE, `st`=0, `rnd`=0, `out_valid`=0, `in_ready`=1, `busy`=0, `rk_addr`=10, `plaintext`=0.
- Reset asserted mid-block: the block is discarded and no `out_valid` pulse is produced. The first accept after reset deassertion is a fresh block.
- Latency: accept at edge E0. ROUND occupies E1..E9 (`rnd` 9→1). FINAL updates at E10. `out_valid` is high from after E10, i.e. 11 cycles after the accept edge.
- Throughput with `out_ready` held high: one block every 11 cycles, with no bubble because of the DONE-to-ROUND bypass.
- `plaintext` and `out_valid` are registered and do not change while `out_valid=1 & out_ready=0` (backpressure of any length).
- `rk_addr` is a combinational decode of state and `rnd` only. It has no path from `in_valid` or `out_ready`.
- `rk_addr` sequence per block: 10, 9, 8, …, 1, 0.

## Test plan
- FIPS-197 C.1: key 000102…0f (store preloaded, `rk_data`[10]=13111d7fe3944a17f307a78b4d2b30c5), ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, `out_ready`=1. Required: `plaintext`=00112233445566778899aabbccddeeff with `out_valid` rising exactly 11 cycles after accept, and `rk_addr` trace 10,9,…,1,0.
- Backpressure: same vector with `out_ready`=0 for 20 cycles after `out_valid`. Required: `plaintext` and `out_valid` stable, `in_ready`=0 throughout, and `in_ready`=1 only in the cycle `out_ready` rises.
- Back-to-back: two C.1 blocks with `in_valid` and `out_ready` held high. Required: second accept in the same cycle the first result is consumed, and the second `out_valid` 11 cycles later with the same plaintext.
- Reset mid-block: assert `rst` at cycle 5 after accept. Required: outputs return to reset values immediately and no `out_valid` occurs. The next C.1 block decrypts correctly.
- Busy/handshake: `in_valid` held high during ROUND and FINAL. Required: `busy`=1 for exactly 10 cycles, `in_ready`=0, and no extra accept.
- Random regression: 1000 random key/ciphertext pairs checked against a software AES-128 model, with random `out_ready` stalls.
